// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store stage with lane select, extension and RMW sub-word stores
// Misaligned trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int ADDR_W = 5
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misaligned,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, RD, MERGE_WR, WR} state_t;

  state_t      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rmw_q, rmw_d;
  logic        trap_q, trap_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;

  logic        is_word, is_half, trap_req;
  logic [1:0]  acc_off;
  logic [31:0] shifted, load_val, lane_mask, merged;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign req_ready  = (state_q == IDLE) && !trap_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign misaligned = misaligned_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;

  always_comb begin
    is_word = req_size[1];
    is_half = (req_size == 2'b01);
    acc_off = req_addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    trap_req = (is_half && req_addr[0]) || (is_word && (req_addr[1:0] != 2'b00));
`else
    // Without trapping, misaligned offsets are silently rounded down to alignment.
    trap_req = 1'b0;
    if (is_word) acc_off = 2'b00;
    else if (is_half) acc_off[0] = 1'b0;
`endif
  end

  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_val = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: load_val = mem_rdata;
    endcase
    lane_mask = (size_q == 2'b00) ? (32'h0000_00FF << {off_q, 3'b000})
                                  : (32'h0000_FFFF << {off_q, 3'b000});
    merged = (mem_rdata & ~lane_mask) | ((wdata_q << {off_q, 3'b000}) & lane_mask);
  end

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    signed_d     = signed_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    rmw_d        = rmw_q;
    trap_d       = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    misaligned_d = 1'b0;
    mem_addr_d   = 32'h0;
    mem_wdata_d  = 32'h0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (trap_q) begin
          resp_valid_d = 1'b1;
          misaligned_d = 1'b1;
        end else if (req_valid) begin
          size_d   = is_word ? 2'b10 : req_size;
          signed_d = req_signed;
          off_d    = acc_off;
          wdata_d  = req_wdata;
          rmw_d    = req_write && !is_word;
          if (trap_req) begin
            trap_d = 1'b1;
          end else begin
            mem_addr_d = {{(32-ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};
            if (req_write && is_word) begin
              state_d     = WR;
              mem_write_d = 1'b1;
              mem_wdata_d = req_wdata;
            end else begin
              state_d    = RD;
              mem_read_d = 1'b1;
            end
          end
        end
      end
      RD: begin
        if (rmw_q) begin
          state_d     = MERGE_WR;
          mem_addr_d  = mem_addr_q;
          mem_write_d = 1'b1;
          mem_wdata_d = merged;
        end else begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_val;
        end
      end
      MERGE_WR, WR: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= 32'h0;
      rmw_q        <= 1'b0;
      trap_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      misaligned_q <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      rmw_q        <= rmw_d;
      trap_q       <= trap_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      misaligned_q <= misaligned_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with falling-edge word memory
module tb_load_store_unit;
  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misaligned;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata = 32'h0;

  load_store_unit #(.ADDR_W(5)) dut (
    .Clk(Clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .misaligned(misaligned), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [32];
  int          cyc = 0;
  int          chk_cnt = 0;
  int          fail_cnt = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wdata = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  // Word memory acting on the falling edge.
  always @(negedge Clk) begin
    check_eq("rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'h0);
    if (mem_read || mem_write)
      check_eq("mem_addr_hi", {5'b0, mem_addr[31:5]}, 32'h0);
    if (mem_write) begin
      mem[mem_addr[4:0]] = mem_wdata;
      wr_cnt++;
      last_wdata = mem_wdata;
    end
    if (mem_read) begin
      mem_rdata <= mem[mem_addr[4:0]];
      rd_cnt++;
    end
  end

  always @(posedge Clk) begin
    #1;
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("resp_unexpected", {31'b0, resp_valid}, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq({e.name, "_cycle"}, cyc, e.cyc);
        check_eq({e.name, "_rdata"}, resp_rdata, e.rdata);
        check_eq({e.name, "_mis"}, {31'b0, misaligned}, {31'b0, e.mis});
      end
    end
  end

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 20) begin
      @(posedge Clk); #1;
      g++;
    end
    check_eq({name, "_drain"}, exp_q.size(), 0);
    @(posedge Clk); #1;
  endtask

  task automatic do_req(input string name, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_mis, input int lat);
    int acc;
    int g;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    g = 0;
    while (!req_ready && g < 20) begin
      @(posedge Clk); #1;
      g++;
    end
    if (!req_ready) begin
      check_eq({name, "_accept"}, {31'b0, req_ready}, 32'h1);
      req_valid = 1'b0;
    end else begin
      acc = cyc + 1;
      @(posedge Clk); #1;
      req_valid = 1'b0;
      rd_cnt = 0;
      wr_cnt = 0;
      exp_q.push_back('{name, acc + lat, exp_rd, exp_mis});
      wait_drain(name);
    end
  endtask

  initial begin
    int acc1;
    int acc2;
    int g;
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000 + i;
    mem[7] = 32'd666;
    mem[9] = 32'd555;

    repeat (3) @(posedge Clk);
    #1;
    check_eq("rst_ready", {31'b0, req_ready}, 32'h1);
    check_eq("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check_eq("rst_rdata", resp_rdata, 32'h0);
    check_eq("rst_mis", {31'b0, misaligned}, 32'h0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    check_eq("rst_mem_rw", {30'b0, mem_read, mem_write}, 32'h0);
    reset = 1'b0;
    @(posedge Clk); #1;

    do_req("lw_1c",  1'b0, 2'b10, 1'b0, 32'h1C, 32'h0, 32'h0000029A, 1'b0, 1);
    do_req("sw_20",  1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 1);
    check_eq("sw_20_wr_cnt", wr_cnt, 1);
    check_eq("sw_20_rd_cnt", rd_cnt, 0);
    do_req("lb_20",  1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 32'hFFFFFFEF, 1'b0, 1);
    do_req("lbu_23", 1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'h000000DE, 1'b0, 1);
    do_req("lh_22",  1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'hFFFFDEAD, 1'b0, 1);
    do_req("lhu_20", 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 32'h0000BEEF, 1'b0, 1);
    do_req("lbu_wrap", 1'b0, 2'b00, 1'b0, 32'h223, 32'h0, 32'h000000DE, 1'b0, 1);

    do_req("sb_25",  1'b1, 2'b00, 1'b0, 32'h25, 32'h55, 32'h0, 1'b0, 2);
    check_eq("sb_25_rd_cnt", rd_cnt, 1);
    check_eq("sb_25_wr_cnt", wr_cnt, 1);
    check_eq("sb_25_wdata", last_wdata, 32'h0000552B);
    do_req("lw_24",  1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 32'h0000552B, 1'b0, 1);

    do_req("sh_22",  1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF1234, 32'h0, 1'b0, 2);
    do_req("lw11_20", 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'h1234BEEF, 1'b0, 1);

`ifdef LSU_MISALIGN_TRAP_EN
    do_req("lw_1e",  1'b0, 2'b10, 1'b0, 32'h1E, 32'h0, 32'h0, 1'b1, 1);
    check_eq("lw_1e_rd_cnt", rd_cnt, 0);
    check_eq("lw_1e_wr_cnt", wr_cnt, 0);
`else
    do_req("lw_1e",  1'b0, 2'b10, 1'b0, 32'h1E, 32'h0, 32'h0000029A, 1'b0, 1);
    check_eq("lw_1e_rd_cnt", rd_cnt, 1);
    check_eq("lw_1e_wr_cnt", wr_cnt, 0);
`endif

    // Reset lands inside the RD cycle of a sub-word store.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 32'h26; req_wdata = 32'h1234;
    @(posedge Clk); #1;
    req_valid = 1'b0;
    rd_cnt = 0;
    wr_cnt = 0;
    reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check_eq("rstmid_ready", {31'b0, req_ready}, 32'h1);
    reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_eq("rstmid_wr_cnt", wr_cnt, 0);
    check_eq("rstmid_word9", mem[9], 32'h0000552B);
    do_req("rstmid_lw_24", 1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 32'h0000552B, 1'b0, 1);

    // Back-to-back loads with req_valid held high.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h1C;
    acc1 = cyc + 1;
    @(posedge Clk); #1;
    exp_q.push_back('{"b2b_first", acc1 + 1, 32'h0000029A, 1'b0});
    req_addr = 32'h24;
    check_eq("b2b_ready_low", {31'b0, req_ready}, 32'h0);
    g = 0;
    while (!req_ready && g < 20) begin
      @(posedge Clk); #1;
      g++;
    end
    acc2 = cyc + 1;
    @(posedge Clk); #1;
    req_valid = 1'b0;
    exp_q.push_back('{"b2b_second", acc2 + 1, 32'h0000552B, 1'b0});
    check_eq("b2b_gap", acc2 - acc1, 2);
    wait_drain("b2b");

    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
